dcache_write_buffer: RTL and testbench



---
 rtl/dcache_write_buffer.sv | 131 +++++++++++++
 tb/tb_dcache_write_buffer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: FIFO of pending dcache line/store writes drained
// one at a time to the AXI write port, with RAW address lookup.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_wr_req,
    input  logic [2:0]   in_wr_type,
    input  logic [31:0]  in_wr_addr,
    input  logic [3:0]   in_wstrb,
    input  logic [127:0] in_wdata,
    output logic         in_wr_rdy,
    output logic         out_wr_req,
    output logic [2:0]   out_wr_type,
    output logic [31:0]  out_wr_addr,
    output logic [3:0]   out_wstrb,
    output logic [127:0] out_wdata,
    input  logic         out_wr_rdy,
    input  logic [31:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [127:0] lookup_data,
    output logic         empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_type  [DEPTH];
    logic [31:0]        r_addr  [DEPTH];
    logic [3:0]         r_wstrb [DEPTH];
    logic [127:0]       r_data  [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_hit;
    logic [127:0]       w_ldata;

    // Ready depends only on the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_wr_rdy = resetn & (r_count != L_DEPTH);
    assign w_push    = in_wr_req & in_wr_rdy;
    assign w_pop     = (r_state == S_WAIT) & out_wr_rdy;

    assign out_wr_req  = (r_state == S_REQ);
    assign out_wr_type = r_type[r_rd_ptr];
    assign out_wr_addr = r_addr[r_rd_ptr];
    assign out_wstrb   = r_wstrb[r_rd_ptr];
    assign out_wdata   = r_data[r_rd_ptr];
    assign empty       = (r_count == '0) && (r_state == S_IDLE);
    assign lookup_hit  = w_hit;
    assign lookup_data = w_ldata;

    // Entry storage: write the tail slot on a push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i]  <= '0;
                r_addr[i]  <= '0;
                r_wstrb[i] <= '0;
                r_data[i]  <= '0;
            end
        end else if (w_push) begin
            r_type[r_wr_ptr]  <= in_wr_type;
            r_addr[r_wr_ptr]  <= in_wr_addr;
            r_wstrb[r_wr_ptr] <= in_wstrb;
            r_data[r_wr_ptr]  <= in_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Drain FSM next state: request, wait for the write response, then pop.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (r_count != '0 && out_wr_rdy) w_state_nxt = S_REQ;
            S_REQ:  if (out_wr_rdy) w_state_nxt = S_WAIT;
            S_WAIT: if (out_wr_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lookup walks entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        w_hit   = 1'b0;
        w_ldata = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (((PTR_W+1)'(k) < r_count) &&
                (r_addr[w_idx][31:4] == lookup_addr[31:4])) begin
                w_hit   = 1'b1;
                w_ldata = r_data[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed scenario tests for dcache_write_buffer.
// Each task drives one scenario and checks its own expected values.
module tb_dcache_write_buffer;

    logic         clk;
    logic         resetn;
    logic         in_wr_req;
    logic [2:0]   in_wr_type;
    logic [31:0]  in_wr_addr;
    logic [3:0]   in_wstrb;
    logic [127:0] in_wdata;
    logic         in_wr_rdy;
    logic         out_wr_req;
    logic [2:0]   out_wr_type;
    logic [31:0]  out_wr_addr;
    logic [3:0]   out_wstrb;
    logic [127:0] out_wdata;
    logic         out_wr_rdy;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic         empty;

    int n_pass;
    int n_total;

    dcache_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_wr_req   (in_wr_req),
        .in_wr_type  (in_wr_type),
        .in_wr_addr  (in_wr_addr),
        .in_wstrb    (in_wstrb),
        .in_wdata    (in_wdata),
        .in_wr_rdy   (in_wr_rdy),
        .out_wr_req  (out_wr_req),
        .out_wr_type (out_wr_type),
        .out_wr_addr (out_wr_addr),
        .out_wstrb   (out_wstrb),
        .out_wdata   (out_wdata),
        .out_wr_rdy  (out_wr_rdy),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d,
                        input logic [2:0] t);
        in_wr_addr = a;
        in_wdata   = d;
        in_wr_type = t;
        in_wstrb   = 4'hF;
        in_wr_req  = 1'b1;
        tick();
        in_wr_req  = 1'b0;
    endtask

    // Act as downstream: wait for a request, capture it, accept it,
    // then drop ready to hold the buffer in WAIT.
    task automatic req_accept(output logic tmo, output logic [31:0] a,
                              output logic [127:0] d);
        tmo = 1'b1;
        a   = '0;
        d   = '0;
        out_wr_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_wr_req) begin
                tmo = 1'b0;
                break;
            end
            tick();
        end
        if (!tmo) begin
            a = out_wr_addr;
            d = out_wdata;
            tick();
        end
        out_wr_rdy = 1'b0;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        in_wr_req   = 1'b0;
        in_wr_type  = '0;
        in_wr_addr  = '0;
        in_wstrb    = '0;
        in_wdata    = '0;
        out_wr_rdy  = 1'b1;
        lookup_addr = '0;
        tick();
        tick();
        n_total++;
        if (in_wr_rdy !== 1'b0) $display("FAIL rst_in_wr_rdy got=%0h exp=0", in_wr_rdy);
        else n_pass++;
        n_total++;
        if (out_wr_req !== 1'b0) $display("FAIL rst_out_wr_req got=%0h exp=0", out_wr_req);
        else n_pass++;
        n_total++;
        if (empty !== 1'b1) $display("FAIL rst_empty got=%0h exp=1", empty);
        else n_pass++;
        n_total++;
        if (lookup_hit !== 1'b0) $display("FAIL rst_lookup_hit got=%0h exp=0", lookup_hit);
        else n_pass++;
        n_total++;
        if (out_wr_addr !== 32'h0 || out_wdata !== 128'h0)
            $display("FAIL rst_out_fields got=%0h/%0h exp=0/0", out_wr_addr, out_wdata);
        else n_pass++;
        resetn = 1'b1;
        #1;
        n_total++;
        if (in_wr_rdy !== 1'b1) $display("FAIL rel_in_wr_rdy got=%0h exp=1", in_wr_rdy);
        else n_pass++;
    endtask

    task automatic test_single_line();
        logic [127:0] d;
        d = 128'h0F0E0D0C_0B0A0908_07060504_DDCCBBAA;
        out_wr_rdy = 1'b1;
        push(32'h0000_1040, d, 3'b100);
        n_total++;
        if (out_wr_req !== 1'b0) $display("FAIL single_req_early got=%0h exp=0", out_wr_req);
        else n_pass++;
        n_total++;
        if (empty !== 1'b0) $display("FAIL single_empty_after_push got=%0h exp=0", empty);
        else n_pass++;
        tick();
        n_total++;
        if (out_wr_req !== 1'b1) $display("FAIL single_req_rise got=%0h exp=1", out_wr_req);
        else n_pass++;
        n_total++;
        if (out_wr_addr !== 32'h0000_1040 || out_wr_type !== 3'b100 || out_wdata !== d)
            $display("FAIL single_fields got=%0h/%0h exp=1040/4", out_wr_addr, out_wr_type);
        else n_pass++;
        tick();
        out_wr_rdy = 1'b0;
        n_total++;
        if (out_wr_req !== 1'b0) $display("FAIL single_req_drop got=%0h exp=0", out_wr_req);
        else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_total++;
        if (empty !== 1'b0 || out_wr_addr !== 32'h0000_1040)
            $display("FAIL single_wait_hold got=%0h/%0h exp=0/1040", empty, out_wr_addr);
        else n_pass++;
        out_wr_rdy = 1'b1;
        tick();
        n_total++;
        if (empty !== 1'b1) $display("FAIL single_pop_empty got=%0h exp=1", empty);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic         tmo;
        logic [31:0]  a;
        logic [127:0] d;
        out_wr_rdy = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h2000 + 32'(i) * 32'h40, 128'hA0 + 128'(i), 3'b100);
        n_total++;
        if (in_wr_rdy !== 1'b0) $display("FAIL fill_full_rdy got=%0h exp=0", in_wr_rdy);
        else n_pass++;
        push(32'h2F00, 128'hEE, 3'b100);
        n_total++;
        if (in_wr_rdy !== 1'b0) $display("FAIL fill_5th_rdy got=%0h exp=0", in_wr_rdy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            req_accept(tmo, a, d);
            n_total++;
            if (tmo || a !== 32'h2000 + 32'(i) * 32'h40 || d !== 128'hA0 + 128'(i))
                $display("FAIL fill_order%0d got=%0h/%0h exp=%0h", i, a, d,
                         32'h2000 + 32'(i) * 32'h40);
            else n_pass++;
            tick();
            if (i == 0) begin
                n_total++;
                if (in_wr_rdy !== 1'b0) $display("FAIL fill_rdy_pre_pop got=%0h exp=0", in_wr_rdy);
                else n_pass++;
            end
            out_wr_rdy = 1'b1;
            tick();
            if (i == 0) begin
                n_total++;
                if (in_wr_rdy !== 1'b1) $display("FAIL fill_rdy_post_pop got=%0h exp=1", in_wr_rdy);
                else n_pass++;
            end
        end
        tick();
        n_total++;
        if (empty !== 1'b1 || out_wr_req !== 1'b0)
            $display("FAIL fill_5th_dropped got=%0h/%0h exp=1/0", empty, out_wr_req);
        else n_pass++;
    endtask

    task automatic test_lookup();
        logic         tmo;
        logic [31:0]  a;
        logic [127:0] d;
        out_wr_rdy = 1'b0;
        push(32'h100, 128'h1111, 3'b010);
        push(32'h108, 128'h2222, 3'b010);
        lookup_addr = 32'h10C;
        #1;
        n_total++;
        if (lookup_hit !== 1'b1 || lookup_data !== 128'h2222)
            $display("FAIL lk_youngest got=%0h/%0h exp=1/2222", lookup_hit, lookup_data);
        else n_pass++;
        lookup_addr = 32'h110;
        #1;
        n_total++;
        if (lookup_hit !== 1'b0 || lookup_data !== 128'h0)
            $display("FAIL lk_miss got=%0h/%0h exp=0/0", lookup_hit, lookup_data);
        else n_pass++;
        lookup_addr = 32'h200;
        in_wr_addr  = 32'h200;
        in_wdata    = 128'h3333;
        in_wr_type  = 3'b010;
        in_wr_req   = 1'b1;
        #1;
        n_total++;
        if (lookup_hit !== 1'b0) $display("FAIL lk_same_cycle_push got=%0h exp=0", lookup_hit);
        else n_pass++;
        tick();
        in_wr_req = 1'b0;
        n_total++;
        if (lookup_hit !== 1'b1 || lookup_data !== 128'h3333)
            $display("FAIL lk_after_push got=%0h/%0h exp=1/3333", lookup_hit, lookup_data);
        else n_pass++;
        lookup_addr = 32'h100;
        req_accept(tmo, a, d);
        tick();
        n_total++;
        if (tmo || a !== 32'h100 || lookup_hit !== 1'b1 || lookup_data !== 128'h2222)
            $display("FAIL lk_in_wait got=%0h/%0h exp=1/2222", lookup_hit, lookup_data);
        else n_pass++;
        out_wr_rdy = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            req_accept(tmo, a, d);
            out_wr_rdy = 1'b1;
            tick();
        end
        tick();
        n_total++;
        if (empty !== 1'b1 || lookup_hit !== 1'b0)
            $display("FAIL lk_drained got=%0h/%0h exp=1/0", empty, lookup_hit);
        else n_pass++;
    endtask

    task automatic test_full_pop_push();
        logic         tmo;
        logic [31:0]  a;
        logic [127:0] d;
        logic [31:0]  exp_a [4];
        out_wr_rdy = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h4000 + 32'(i) * 32'h10, 128'hD0 + 128'(i), 3'b010);
        req_accept(tmo, a, d);
        n_total++;
        if (tmo || a !== 32'h4000) $display("FAIL fp_head got=%0h exp=4000", a);
        else n_pass++;
        tick();
        in_wr_addr = 32'h4800;
        in_wdata   = 128'hE0;
        in_wr_type = 3'b010;
        in_wr_req  = 1'b1;
        out_wr_rdy = 1'b1;
        #1;
        n_total++;
        if (in_wr_rdy !== 1'b0) $display("FAIL fp_refused got=%0h exp=0", in_wr_rdy);
        else n_pass++;
        tick();
        n_total++;
        if (in_wr_rdy !== 1'b1) $display("FAIL fp_rdy_after_pop got=%0h exp=1", in_wr_rdy);
        else n_pass++;
        tick();
        in_wr_req = 1'b0;
        n_total++;
        if (in_wr_rdy !== 1'b0) $display("FAIL fp_full_again got=%0h exp=0", in_wr_rdy);
        else n_pass++;
        exp_a[0] = 32'h4010;
        exp_a[1] = 32'h4020;
        exp_a[2] = 32'h4030;
        exp_a[3] = 32'h4800;
        for (int i = 0; i < 4; i++) begin
            req_accept(tmo, a, d);
            n_total++;
            if (tmo || a !== exp_a[i])
                $display("FAIL fp_wrap_order%0d got=%0h exp=%0h", i, a, exp_a[i]);
            else n_pass++;
            out_wr_rdy = 1'b1;
            tick();
        end
        tick();
        n_total++;
        if (empty !== 1'b1) $display("FAIL fp_empty got=%0h exp=1", empty);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic         tmo;
        logic [31:0]  a;
        logic [127:0] d;
        logic         seen;
        out_wr_rdy = 1'b0;
        push(32'h300, 128'h55, 3'b100);
        push(32'h310, 128'h66, 3'b100);
        lookup_addr = 32'h300;
        req_accept(tmo, a, d);
        tick();
        n_total++;
        if (tmo || empty !== 1'b0 || lookup_hit !== 1'b1)
            $display("FAIL ar_pre got=%0h/%0h exp=0/1", empty, lookup_hit);
        else n_pass++;
        #3;
        resetn = 1'b0;
        #1;
        n_total++;
        if (out_wr_req !== 1'b0 || empty !== 1'b1 || lookup_hit !== 1'b0 || in_wr_rdy !== 1'b0)
            $display("FAIL ar_immediate got=%0h/%0h/%0h exp=0/1/0",
                     out_wr_req, empty, lookup_hit);
        else n_pass++;
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        out_wr_rdy = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_wr_req) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || empty !== 1'b1)
            $display("FAIL ar_no_stale got=%0h/%0h exp=0/1", seen, empty);
        else n_pass++;
    endtask

    task automatic test_push_on_pop();
        logic         tmo;
        logic [31:0]  a;
        logic [127:0] d;
        out_wr_rdy = 1'b0;
        push(32'h400, 128'h77, 3'b010);
        req_accept(tmo, a, d);
        tick();
        in_wr_addr = 32'h500;
        in_wdata   = 128'h88;
        in_wr_type = 3'b010;
        in_wr_req  = 1'b1;
        out_wr_rdy = 1'b1;
        tick();
        in_wr_req = 1'b0;
        n_total++;
        if (tmo || empty !== 1'b0 || out_wr_addr !== 32'h500)
            $display("FAIL pp_new_head got=%0h/%0h exp=0/500", empty, out_wr_addr);
        else n_pass++;
        req_accept(tmo, a, d);
        n_total++;
        if (tmo || a !== 32'h500 || d !== 128'h88)
            $display("FAIL pp_next_req got=%0h/%0h exp=500/88", a, d);
        else n_pass++;
        out_wr_rdy = 1'b1;
        tick();
        n_total++;
        if (empty !== 1'b1) $display("FAIL pp_count_one got=%0h exp=1", empty);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_line();
        test_fill_drain();
        test_lookup();
        test_full_pop_push();
        test_async_reset();
        test_push_on_pop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
